// File: rtl/dl_lshift_seq.sv
// Multi-cycle logical left shifter, one logarithmic stage per cycle, valid/ready on both sides.
// Optional macro DL_LSHIFT_SEQ_EARLY_DONE_EN: leave BUSY as soon as no shift bits remain.
`timescale 1ns/1ps

module dl_lshift_seq #(
   parameter  int NUM_BITS       = 32,
   localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_val,
   output logic                      in_rdy,
   input  logic [NUM_BITS-1:0]       in,
   input  logic [NUM_SHIFT_BITS-1:0] shift,
   output logic                      out_val,
   input  logic                      out_rdy,
   output logic [NUM_BITS-1:0]       out,
   output logic                      busy
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   localparam logic [NUM_SHIFT_BITS-1:0] LAST_STAGE = NUM_SHIFT_BITS'(NUM_SHIFT_BITS - 1);

   state_e                    state_q, state_d;
   logic [NUM_BITS-1:0]       data_q, data_d;
   logic [NUM_SHIFT_BITS-1:0] amt_q, amt_d;
   logic [NUM_SHIFT_BITS-1:0] stage_q, stage_d;

   logic [NUM_BITS-1:0]       stage_data;
   logic [NUM_SHIFT_BITS-1:0] amt_rem;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         amt_q   <= '0;
         stage_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         amt_q   <= amt_d;
         stage_q <= stage_d;
      end
   end

   // Stage k shifts by the constant 2^k; selecting among constants avoids a full barrel shifter.
   always_comb begin
      stage_data = data_q;
      for (int k = 0; k < NUM_SHIFT_BITS; k++) begin
         if (stage_q == NUM_SHIFT_BITS'(k)) begin
            stage_data = data_q << (2 ** k);
         end
      end
   end

   assign amt_rem = amt_q >> 1;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      amt_d   = amt_q;
      stage_d = stage_q;

      unique case (state_q)
         IDLE: begin
            if (in_val && in_rdy) begin
               data_d  = in;
               amt_d   = shift;
               stage_d = '0;
`ifdef DL_LSHIFT_SEQ_EARLY_DONE_EN
               state_d = (shift == '0) ? DONE : BUSY;
`else
               state_d = BUSY;
`endif
            end
         end

         BUSY: begin
            if (amt_q[0]) begin
               data_d = stage_data;
            end
            amt_d   = amt_rem;
            stage_d = stage_q + NUM_SHIFT_BITS'(1);
            if (stage_q == LAST_STAGE) begin
               state_d = DONE;
            end
`ifdef DL_LSHIFT_SEQ_EARLY_DONE_EN
            else if (amt_rem == '0) begin
               state_d = DONE;
            end
`endif
         end

         DONE: begin
            // Returning through IDLE keeps a result handshake and a new accept in separate cycles.
            if (out_rdy) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign in_rdy  = (state_q == IDLE) && !rst;
   assign out_val = (state_q == DONE);
   assign busy    = (state_q != IDLE);
   assign out     = data_q;

endmodule

// File: tb/tb_dl_lshift_seq.sv
// Directed + random self-checking bench for dl_lshift_seq (NUM_BITS = 32).
`timescale 1ns/1ps

module tb_dl_lshift_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_val;
   logic        in_rdy;
   logic [31:0] in_d;
   logic [4:0]  shift_d;
   logic        out_val;
   logic        out_rdy;
   logic [31:0] out_q;
   logic        busy;

   int n_checks = 0;
   int n_fails  = 0;

   dl_lshift_seq #(.NUM_BITS(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_val  (in_val),
      .in_rdy  (in_rdy),
      .in      (in_d),
      .shift   (shift_d),
      .out_val (out_val),
      .out_rdy (out_rdy),
      .out     (out_q),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Edges counted after the accepting edge until out_val is seen.
   function automatic int exp_latency(input logic [4:0] s);
`ifdef DL_LSHIFT_SEQ_EARLY_DONE_EN
      int h = 0;
      for (int i = 0; i < 5; i++) begin
         if (s[i]) h = i + 1;
      end
      return h;
`else
      return 5;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts and ends 1 time unit after a rising edge.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] s,
                         input logic [31:0] exp, input int pre, input int stall,
                         input bit poke_in);
      int wait_n;
      int lat;
      out_rdy = 1'b0;
      repeat (pre) tick();
      wait_n = 0;
      while (!in_rdy && wait_n < 50) begin
         tick();
         wait_n++;
      end
      check({tag, " in_rdy"}, 32'(in_rdy), 32'd1);

      in_val  = 1'b1;
      in_d    = a;
      shift_d = s;
      tick();
      in_val  = 1'b0;
      in_d    = ~a;
      shift_d = ~s;
      check({tag, " busy after accept"}, 32'(busy), 32'd1);
      check({tag, " in_rdy low after accept"}, 32'(in_rdy), 32'd0);

      lat = 0;
      while (!out_val && lat < 64) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_latency(s)));
      check({tag, " result"}, out_q, exp);

      for (int i = 0; i < stall; i++) begin
         if (poke_in) begin
            in_val  = ~in_val;
            in_d    = 32'h1234_5678;
            shift_d = 5'd1;
         end
         tick();
         check({tag, " stall out_val"}, 32'(out_val), 32'd1);
         check({tag, " stall out"}, out_q, exp);
         check({tag, " stall in_rdy"}, 32'(in_rdy), 32'd0);
      end

      out_rdy = 1'b1;
      tick();
      out_rdy = 1'b0;
      in_val  = 1'b0;
      check({tag, " out_val drop"}, 32'(out_val), 32'd0);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      check({tag, " in_rdy after handshake"}, 32'(in_rdy), 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int seen;
      logic [31:0] a;
      logic [4:0]  s;

      rst     = 1'b1;
      in_val  = 1'b0;
      in_d    = '0;
      shift_d = '0;
      out_rdy = 1'b0;
      #2;
      check("reset in_rdy", 32'(in_rdy), 32'd0);
      check("reset out_val", 32'(out_val), 32'd0);
      check("reset out", out_q, 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("post-reset in_rdy", 32'(in_rdy), 32'd1);
      tick();

      run_op("basic", 32'h0000_0001, 5'd31, 32'h8000_0000, 0, 0, 1'b0);
      run_op("mixed13", 32'hDEAD_BEEF, 5'd13, 32'hB7DD_E000, 0, 0, 1'b0);
      run_op("shift0", 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 0, 1'b0);
      run_op("ones31", 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 0, 1, 1'b0);
      run_op("lsb0_31", 32'hDEAD_BEEE, 5'd31, 32'h0000_0000, 0, 0, 1'b0);
      run_op("a5_4", 32'hA5A5_A5A5, 5'd4, 32'h5A5A_5A50, 0, 0, 1'b0);
      run_op("s16", 32'h1234_5678, 5'd16, 32'h5678_0000, 0, 0, 1'b0);
      run_op("s8", 32'h0F0F_0F0F, 5'd8, 32'h0F0F_0F00, 0, 0, 1'b0);
      run_op("msb_drop", 32'h8000_0001, 5'd1, 32'h0000_0002, 0, 0, 1'b0);
      run_op("backpressure", 32'h0000_00FF, 5'd3, 32'h0000_07F8, 0, 10, 1'b1);

      // Abort during BUSY: reset lands while stage 2 is in progress.
      in_val  = 1'b1;
      in_d    = 32'hFFFF_FFFF;
      shift_d = 5'd4;
      tick();
      in_val = 1'b0;
      tick();
      tick();
      check("abort busy before reset", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("abort out_val", 32'(out_val), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort in_rdy", 32'(in_rdy), 32'd0);
      check("abort out", out_q, 32'd0);
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_val) seen++;
      end
      check("abort no out_val", 32'(seen), 32'd0);
      run_op("after abort", 32'h0000_0001, 5'd1, 32'h0000_0002, 0, 0, 1'b0);

      for (int n = 0; n < 1500; n++) begin
         a = $urandom;
         s = 5'($urandom_range(0, 31));
         run_op("random", a, s, a << s, $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
